deser16_1: RTL and testbench
============================

// Module: deser16_1
// PURPOSE
//  Serial-to-parallel bit collector; the receive-side inverse of a mux16_1 serializer.
//  - A transmitter walks sel 0..15 through mux16_1 and sends one bit per beat.
//  - This block steers each accepted bit into word position idx through a one-hot decoder.
//  - It presents the 16-bit word on a valid/ready output handshake.
//  - It sits between a serial link or scan path and the CPU's parallel datapath.
// PARAMETERS
//  WIDTH  16  word width; power of two, >= 2
//  IDXW   $clog2(WIDTH)  localparam; width of the bit index
// PORTS
//  clk        in   1      rising-edge clock; the only clock
//  reset      in   1      asynchronous, active-high reset
//  clear      in   1      synchronous flush of the partial/full word
//  in_valid   in   1      in_bit is valid this cycle
//  in_bit     in   1      serial data bit; LSB first
//  in_ready   out  1      block accepts in_bit this cycle
//  out_valid  out  1      out_data holds a complete word
//  out_data   out  WIDTH  assembled word; bit i = i-th accepted bit
//  out_ready  in   1      consumer takes out_data this cycle
//  bit_idx    out  IDXW   position the next accepted bit writes
// BEHAVIOUR
//  Reset (async assert, sync-safe deassert):
//   - state=FILL, bit_idx=0, out_valid=0, out_data=0; in_ready=1 once reset is low.
//  Definitions: accept = in_valid & in_ready; take = out_valid & out_ready.
//  State FILL (out_valid=0, in_ready=1):
//   - accept: out_data[bit_idx] <= in_bit; all other bits hold; bit_idx++.
//   - accept with bit_idx==WIDTH-1: bit_idx wraps to 0; state->FULL, so out_valid=1 the next cycle.
//  State FULL (out_valid=1):
//   - out_data is held stable until take.
//   - in_ready = out_ready; a bit is accepted only in the cycle the word is taken (pipelined, no bubble).
//   - take without accept: state->FILL, bit_idx=0.
//   - take with accept:
//     - out_data[0] <= in_bit; bit_idx=1; state->FILL.
//     - The consumer samples the old out_data before that edge.
//   - in_valid without out_ready: no accept; nothing changes.
//  Latency: the last bit is accepted at edge k; out_valid is high from k until the take edge.
//   - Sustained throughput is one bit per cycle.
//  Bits above bit_idx in FILL hold stale data from the previous word; the consumer ignores out_data while out_valid=0.
//  clear (priority over all handshakes except reset):
//   - Next state FILL, bit_idx=0, out_valid=0; out_data is not zeroed.
//   - A bit offered in a clear cycle is dropped, even though in_ready may be 1.
//  Reset mid-word: the partial word is discarded and all outputs return to their reset values immediately.
//  in_bit is X-tolerant when in_valid=0; out_data never samples it then.
//  State and bit_idx are registered; in_ready is combinational from state and out_ready only (no path from in_valid).
// STRUCTURE
//  deser_pkg:
//   - typedef enum logic {FILL, FULL} deser_state_t;
//   - localparam DESER_WIDTH = 16.
//  Sub-module onehot_decoder #(IDXW):
//   - out[2**IDXW-1:0] = en ? 1<<sel : 0.
//   - Gated with accept, it produces the per-bit write enables into the out_data flops.
//   - This is the decode dual of the mux tree.
//  The top holds the state flop, the IDXW-bit wrapping counter, the WIDTH data flops and the handshake logic.
// TESTING
//  1. Assert reset mid-clock, no clk edge -> out_valid=0, out_data=0, bit_idx=0; after deassert, in_ready=1.
//  2. Send 16'h39CA LSB first, in_valid=1 every cycle, out_ready=0
//     -> out_valid rises the cycle after the 16th bit, out_data=16'h39CA, in_ready=0.
//     -> Hold 5 cycles: data is stable and no bits are accepted.
//  3. Send 16'h39CA then 16'hC635 back-to-back, out_ready=1
//     -> the take of word 1 coincides with bit 0 of word 2.
//     -> Second word = 16'hC635; no idle cycle between the two words.
//  4. Toggle in_valid randomly 50% while sending 16'hA5F0 -> only accepted bits land; out_data=16'hA5F0.
//  5. Accept 7 bits, pulse clear with in_valid=1 -> bit_idx=0, out_valid=0; the next 16 bits of 16'h1234 yield 16'h1234.
//  6. Assert reset at bit_idx=9, and again while FULL -> out_valid=0 and bit_idx=0 immediately;
//     the next full word is assembled correctly.

Source files
------------

// File: rtl/deser_pkg.sv
// deser_pkg: shared types and constants for the deser16_1 serial-to-parallel
// collector.
//   deser_state_t : FILL (collecting bits) / FULL (word presented, waiting for take)
//   DESER_WIDTH   : default assembled word width
package deser_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } deser_state_t;

  localparam int DESER_WIDTH = 16;

endpackage : deser_pkg

// File: rtl/deser16_1_decoder.sv
// onehot_decoder: index-to-one-hot decoder, the decode dual of a mux tree.
// Ports:
//   en  in  1              enable; all outputs are zero when low
//   sel in  IDXW           index to decode
//   out out 2**IDXW        one-hot vector, out[sel] = en
module onehot_decoder #(
  parameter int IDXW = 4
) (
  input  logic                 en,
  input  logic [IDXW-1:0]      sel,
  output logic [2**IDXW-1:0]   out
);

  always_comb begin
    out = '0;
    if (en) begin
      out[sel] = 1'b1;
    end
  end

endmodule : onehot_decoder

// File: rtl/deser16_1.sv
// deser16_1: serial-to-parallel bit collector. Accepted bits are written
// LSB first into out_data at position bit_idx; a complete word is presented
// on a valid/ready output handshake.
//
// Handshake semantics: an input bit transfers on a rising edge where
// in_valid && in_ready (and clear is low); a word transfers on a rising edge
// where out_valid && out_ready. Neither ready depends on its own valid.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high reset
//   clear      in   1      synchronous flush of the partial/full word
//   in_valid   in   1      in_bit is valid this cycle
//   in_bit     in   1      serial data bit, LSB first
//   in_ready   out  1      block accepts in_bit this cycle
//   out_valid  out  1      out_data holds a complete word
//   out_data   out  WIDTH  assembled word, bit i = i-th accepted bit
//   out_ready  in   1      consumer takes out_data this cycle
//   bit_idx    out  IDXW   position the next accepted bit writes
//   state_dbg  out  1      current FSM state, for observation only
module deser16_1
  import deser_pkg::*;
#(
  parameter int WIDTH = DESER_WIDTH,
  localparam int IDXW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [IDXW-1:0]  bit_idx,
  output deser_state_t     state_dbg
);

  deser_state_t     state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] we_vec;
  logic             accept;
  logic             take;

  // In FULL the block can only take a new bit in the cycle the word leaves,
  // so input readiness follows out_ready there.
  assign in_ready  = (state_q == FILL) ? 1'b1 : out_ready;
  assign out_valid = (state_q == FULL);
  // clear drops any offered bit even when in_ready is high.
  assign accept    = in_valid & in_ready & ~clear;
  assign take      = out_valid & out_ready;

  assign out_data  = data_q;
  assign bit_idx   = idx_q;
  assign state_dbg = state_q;

  // In FULL idx_q has already wrapped to 0, so a pipelined accept lands in bit 0.
  onehot_decoder #(.IDXW(IDXW)) u_dec (
    .en  (accept),
    .sel (idx_q),
    .out (we_vec)
  );

  always_comb begin
    data_d = (data_q & ~we_vec) | (we_vec & {WIDTH{in_bit}});
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (clear) begin
      state_d = FILL;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (accept) begin
            idx_d = idx_q + IDXW'(1);  // wraps to 0 after the last bit
            if (idx_q == IDXW'(WIDTH - 1)) begin
              state_d = FULL;
            end
          end
        end
        FULL: begin
          if (take) begin
            state_d = FILL;
            idx_d   = accept ? IDXW'(1) : '0;
          end
        end
        default: begin
          state_d = FILL;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

endmodule : deser16_1

// File: tb/tb_deser16_1.sv
module tb_deser16_1;
  import deser_pkg::*;

  localparam int WIDTH = 16;
  localparam int IDXW  = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic             clear;
  logic             in_valid;
  logic             in_bit;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [IDXW-1:0]  bit_idx;
  deser_state_t     state_dbg;

  int checks   = 0;
  int failures = 0;

  deser16_1 dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .bit_idx   (bit_idx),
    .state_dbg (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs were set beforehand, outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive nbits of w LSB first with in_valid high every cycle.
  task automatic send_bits(input logic [WIDTH-1:0] w, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      in_valid = 1'b1;
      in_bit   = w[i];
      tick();
    end
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  logic [WIDTH-1:0] w1, w2, w4;
  int               got, cyc, v;

  initial begin
    clear = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b0;

    // 1. reset asserted mid-clock before any edge
    #2 reset = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_bit_idx", 32'(bit_idx), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(FILL));
    tick();
    reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // 2. one word with the consumer stalled
    w1 = 16'h39CA;
    out_ready = 1'b0;
    send_bits(w1, 15);
    check("t2_idx15", 32'(bit_idx), 32'd15);
    check("t2_not_valid_yet", 32'(out_valid), 32'd0);
    send_bits(16'(w1[15]) << 15, 0);
    in_valid = 1'b1; in_bit = w1[15];
    tick();
    check("t2_out_valid", 32'(out_valid), 32'd1);
    check("t2_out_data", 32'(out_data), 32'h39CA);
    check("t2_in_ready", 32'(in_ready), 32'd0);
    check("t2_idx_wrap", 32'(bit_idx), 32'd0);
    in_valid = 1'b1; in_bit = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_hold_data", 32'(out_data), 32'h39CA);
      check("t2_hold_valid", 32'(out_valid), 32'd1);
      check("t2_hold_idx", 32'(bit_idx), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("t2_in_ready_follows", 32'(in_ready), 32'd1);
    tick();
    check("t2_taken_valid", 32'(out_valid), 32'd0);
    check("t2_taken_idx", 32'(bit_idx), 32'd0);

    // 3. back-to-back words with the consumer always ready
    w2 = 16'hC635;
    out_ready = 1'b1;
    send_bits(w1, 16);
    check("t3_w1_valid", 32'(out_valid), 32'd1);
    check("t3_w1_data", 32'(out_data), 32'h39CA);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_bit   = w2[i];
      if (i == 0) begin
        #1;
        check("t3_pipe_in_ready", 32'(in_ready), 32'd1);
      end
      tick();
      if (i == 0) begin
        check("t3_after_take_valid", 32'(out_valid), 32'd0);
        check("t3_after_take_idx", 32'(bit_idx), 32'd1);
        check("t3_bit0_landed", 32'(out_data[0]), 32'(w2[0]));
      end
    end
    in_valid = 1'b0;
    check("t3_w2_valid", 32'(out_valid), 32'd1);
    check("t3_w2_data", 32'(out_data), 32'hC635);
    tick();
    check("t3_w2_taken", 32'(out_valid), 32'd0);

    // 4. in_valid toggled randomly, in_bit X when not valid
    w4 = 16'hA5F0;
    out_ready = 1'b0;
    got = 0;
    cyc = 0;
    while (got < 16 && cyc < 400) begin
      v = $urandom_range(0, 1);
      in_valid = v[0];
      in_bit   = v[0] ? w4[got] : 1'bx;
      tick();
      if (v[0]) got++;
      cyc++;
    end
    in_valid = 1'b0; in_bit = 1'b0;
    check("t4_timeout", 32'(got), 32'd16);
    check("t4_valid", 32'(out_valid), 32'd1);
    check("t4_data", 32'(out_data), 32'hA5F0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t4_taken", 32'(out_valid), 32'd0);

    // 5. clear mid-word drops the offered bit
    send_bits(16'hFFFF, 7);
    check("t5_idx7", 32'(bit_idx), 32'd7);
    clear = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    check("t5_clear_idx", 32'(bit_idx), 32'd0);
    check("t5_clear_valid", 32'(out_valid), 32'd0);
    send_bits(16'h1234, 16);
    check("t5_valid", 32'(out_valid), 32'd1);
    check("t5_data", 32'(out_data), 32'h1234);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // 6. reset at bit_idx 9 and again while FULL
    send_bits(16'hFFFF, 9);
    check("t6_idx9", 32'(bit_idx), 32'd9);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_idx", 32'(bit_idx), 32'd0);
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_data", 32'(out_data), 32'h0);
    tick();
    reset = 1'b0;
    send_bits(16'hBEEF, 16);
    check("t6_w1_valid", 32'(out_valid), 32'd1);
    check("t6_w1_data", 32'(out_data), 32'hBEEF);
    #2 reset = 1'b1;
    #1;
    check("t6_full_rst_valid", 32'(out_valid), 32'd0);
    check("t6_full_rst_idx", 32'(bit_idx), 32'd0);
    check("t6_full_rst_data", 32'(out_data), 32'h0);
    tick();
    reset = 1'b0;
    send_bits(16'h5AC3, 16);
    check("t6_w2_valid", 32'(out_valid), 32'd1);
    check("t6_w2_data", 32'(out_data), 32'h5AC3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_deser16_1
